regfile_wb_arbiter: RTL and testbench

//  Shares the register file's single write port between two writeback sources:
//  src0 = ALU pipe, src1 = load/multi-cycle unit.

---
 rtl/regfile_wb_arbiter_pkg.sv | 18 +
 rtl/regfile_wb_arbiter_if.sv | 39 +++
 rtl/regfile_wb_arbiter_rr.sv | 32 +++
 rtl/regfile_wb_arbiter.sv | 116 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and enumerations for the register-file writeback arbiter.
package regfile_pkg;

  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned NUM_REGS = 32;

  typedef enum logic {
    WB_ALU = 1'b0,
    WB_LSU = 1'b1
  } wb_src_e;

  typedef enum logic {
    ST_RUN,
    ST_DRAIN
  } fsm_state_e;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback and reservation handshakes between the pipeline and the arbiter.
interface regfile_wb_arbiter_if #(
  parameter int unsigned ADDR_W = regfile_pkg::ADDR_W,
  parameter int unsigned DATA_W = regfile_pkg::DATA_W
);

  logic              wb0_valid;
  logic [ADDR_W-1:0] wb0_addr;
  logic [DATA_W-1:0] wb0_data;
  logic              wb0_ready;

  logic              wb1_valid;
  logic [ADDR_W-1:0] wb1_addr;
  logic [DATA_W-1:0] wb1_data;
  logic              wb1_ready;

  logic              rsv_valid;
  logic [ADDR_W-1:0] rsv_addr;
  logic              rsv_ready;

  modport master (
    output wb0_valid, wb0_addr, wb0_data,
    input  wb0_ready,
    output wb1_valid, wb1_addr, wb1_data,
    input  wb1_ready,
    output rsv_valid, rsv_addr,
    input  rsv_ready
  );

  modport slave (
    input  wb0_valid, wb0_addr, wb0_data,
    output wb0_ready,
    input  wb1_valid, wb1_addr, wb1_data,
    output wb1_ready,
    input  rsv_valid, rsv_addr,
    output rsv_ready
  );

endinterface

// File: rtl/regfile_wb_arbiter_rr.sv
// Two-way round-robin arbiter; the last-grant pointer moves only on a transfer.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       adv,
  output logic [1:0] gnt
);
  import regfile_pkg::*;

  wb_src_e last;

  // Grant the requester that did not win last time when both ask.
  always_comb begin
    gnt = '0;
    if (req == 2'b11) begin
      gnt = (last == WB_ALU) ? 2'b10 : 2'b01;
    end else begin
      gnt = req;
    end
  end

  // Remember which source won the most recent transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= WB_ALU;
    end else if (adv) begin
      last <= gnt[1] ? WB_LSU : WB_ALU;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port between the ALU and load/MC writeback
// sources and tracks pending destination registers for decode hazard stalls.
module regfile_wb_arbiter #(
  parameter int unsigned DATA_W   = regfile_pkg::DATA_W,
  parameter int unsigned ADDR_W   = regfile_pkg::ADDR_W,
  parameter int unsigned NUM_REGS = regfile_pkg::NUM_REGS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  regfile_wb_arbiter_if.slave   bus,
  input  logic [ADDR_W-1:0]     rs_addr,
  input  logic [ADDR_W-1:0]     rt_addr,
  output logic                  stall,
  input  logic                  flush,
  output logic                  flush_done,
  output logic                  rf_we,
  output logic [ADDR_W-1:0]     rf_waddr,
  output logic [DATA_W-1:0]     rf_wdata,
  output logic [NUM_REGS-1:0]   busy
);
  import regfile_pkg::*;

  fsm_state_e          state;
  fsm_state_e          state_next;
  logic                drain_exit;
  logic [1:0]          gnt;
  logic                xfer;
  logic [ADDR_W-1:0]   xfer_addr;
  logic [DATA_W-1:0]   xfer_data;
  logic                rsv_fire;
  logic [NUM_REGS-1:0] busy_next;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({bus.wb1_valid, bus.wb0_valid}),
    .adv   (xfer),
    .gnt   (gnt)
  );

  // Handshake outputs are forced low while reset is held.
  always_comb begin
    bus.wb0_ready = rst_n & gnt[0];
    bus.wb1_ready = rst_n & gnt[1];
    xfer          = |gnt;
    xfer_addr     = gnt[1] ? bus.wb1_addr : bus.wb0_addr;
    xfer_data     = gnt[1] ? bus.wb1_data : bus.wb0_data;
    bus.rsv_ready = rst_n & (state == ST_RUN) &
                    ((bus.rsv_addr == '0) | ~busy[bus.rsv_addr]);
    rsv_fire      = bus.rsv_valid & bus.rsv_ready;
  end

  // Decode hazard detection; register 0 never stalls.
  always_comb begin
    stall = ((rs_addr != '0) & busy[rs_addr]) |
            ((rt_addr != '0) & busy[rt_addr]);
  end

  // Flush sequencing: DRAIN waits for both sources and the write pipe to empty.
  always_comb begin
    state_next = state;
    drain_exit = 1'b0;
    case (state)
      ST_RUN: begin
        if (flush) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!bus.wb0_valid && !bus.wb1_valid && !rf_we) begin
          state_next = ST_RUN;
          drain_exit = 1'b1;
        end
      end
      default: state_next = ST_RUN;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= state_next;
  end

  // Scoreboard update: retire the register being written, then add the new
  // reservation; a completed drain wipes everything.
  always_comb begin
    busy_next = busy;
    if (rf_we) busy_next[rf_waddr] = 1'b0;
    if (rsv_fire) busy_next[bus.rsv_addr] = 1'b1;
    busy_next[0] = 1'b0;
    if (drain_exit) busy_next = '0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_next;
  end

  // Registered write port and flush completion pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      flush_done <= 1'b0;
    end else begin
      rf_we      <= xfer & (xfer_addr != '0);
      flush_done <= drain_exit;
      if (xfer) begin
        rf_waddr <= xfer_addr;
        rf_wdata <= xfer_data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed corner cases, a
// combinational vector table and a randomized run against a reference model.
module tb_regfile_wb_arbiter;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned NR = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] rs_addr, rt_addr;
  logic          stall, flush, flush_done, rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [NR-1:0] busy;

  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .rs_addr    (rs_addr),
    .rt_addr    (rt_addr),
    .stall      (stall),
    .flush      (flush),
    .flush_done (flush_done),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .busy       (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit            m_busy[NR];
  int unsigned   m_last;      // 0: ALU won last, 1: LSU won last
  bit            m_we;
  int unsigned   m_waddr;
  logic [DW-1:0] m_wdata;
  bit            m_drain;
  bit            m_fd;
  bit            lg0, lg1;

  typedef struct {
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic [AW-1:0] ra;
    bit            st;
    bit            rr;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_last = 0; m_we = 0; m_waddr = 0; m_wdata = '0;
    m_drain = 0; m_fd = 0; lg0 = 0; lg1 = 0;
  endtask

  function automatic bit exp_g0();
    return rst_n && bus.wb0_valid && (!bus.wb1_valid || m_last == 1);
  endfunction

  function automatic bit exp_g1();
    return rst_n && bus.wb1_valid && (!bus.wb0_valid || m_last == 0);
  endfunction

  function automatic bit exp_rr();
    return rst_n && !m_drain && (bus.rsv_addr == 0 || !m_busy[bus.rsv_addr]);
  endfunction

  function automatic bit exp_stall();
    return (rs_addr != 0 && m_busy[rs_addr]) || (rt_addr != 0 && m_busy[rt_addr]);
  endfunction

  function automatic logic [NR-1:0] exp_busy();
    logic [NR-1:0] v;
    for (int i = 0; i < NR; i++) v[i] = m_busy[i];
    return v;
  endfunction

  task automatic compare_now();
    chk("wb0_ready", bus.wb0_ready, exp_g0());
    chk("wb1_ready", bus.wb1_ready, exp_g1());
    chk("rsv_ready", bus.rsv_ready, exp_rr());
    chk("stall", stall, exp_stall());
    chk("rf_we", rf_we, m_we);
    if (m_we) begin
      chk("rf_waddr", rf_waddr, m_waddr);
      chk("rf_wdata", rf_wdata, m_wdata);
    end
    chk("busy", busy, exp_busy());
    chk("flush_done", flush_done, m_fd);
  endtask

  // Apply the edge rules to the model using the inputs present at the edge.
  task automatic model_step();
    bit g0, g1, rr, ex;
    g0 = exp_g0();
    g1 = exp_g1();
    rr = exp_rr();
    ex = m_drain && !bus.wb0_valid && !bus.wb1_valid && !m_we;
    if (m_we) m_busy[m_waddr] = 1'b0;
    if (bus.rsv_valid && rr && bus.rsv_addr != 0) m_busy[bus.rsv_addr] = 1'b1;
    if (ex) begin
      foreach (m_busy[i]) m_busy[i] = 1'b0;
      m_drain = 0;
    end else if (!m_drain && flush) begin
      m_drain = 1;
    end
    m_fd = ex;
    m_we = 0;
    if (g0) begin
      m_last = 0; m_we = (bus.wb0_addr != 0); m_waddr = bus.wb0_addr; m_wdata = bus.wb0_data;
    end else if (g1) begin
      m_last = 1; m_we = (bus.wb1_addr != 0); m_waddr = bus.wb1_addr; m_wdata = bus.wb1_data;
    end
    lg0 = g0;
    lg1 = g1;
  endtask

  task automatic tick();
    @(negedge clk);
    compare_now();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive_idle();
    bus.wb0_valid = 0; bus.wb0_addr = '0; bus.wb0_data = '0;
    bus.wb1_valid = 0; bus.wb1_addr = '0; bus.wb1_data = '0;
    bus.rsv_valid = 0; bus.rsv_addr = '0;
    rs_addr = '0; rt_addr = '0; flush = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit exp_seq[4];
    exp_seq[0] = 1; exp_seq[1] = 0; exp_seq[2] = 1; exp_seq[3] = 0;

    tbl[0] = '{rs: 0, rt: 0, ra: 0, st: 0, rr: 1};
    tbl[1] = '{rs: 4, rt: 0, ra: 4, st: 1, rr: 0};
    tbl[2] = '{rs: 0, rt: 6, ra: 6, st: 1, rr: 0};
    tbl[3] = '{rs: 5, rt: 5, ra: 5, st: 0, rr: 1};
    tbl[4] = '{rs: 4, rt: 6, ra: 0, st: 1, rr: 1};
    tbl[5] = '{rs: 0, rt: 0, ra: 6, st: 0, rr: 0};
    tbl[6] = '{rs: 7, rt: 4, ra: 3, st: 1, rr: 1};
    tbl[7] = '{rs: 1, rt: 2, ra: 4, st: 0, rr: 0};

    // Power-on reset
    rst_n = 0;
    drive_idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, '0);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_flush_done", flush_done, 0);
    bus.wb0_valid = 1;
    #1;
    chk("rst_wb0_ready", bus.wb0_ready, 0);
    bus.wb0_valid = 0;
    rst_n = 1;

    // Reset asserted while a write is in flight
    bus.wb0_valid = 1; bus.wb0_addr = 5; bus.wb0_data = 32'h1234_5678;
    tick();
    bus.wb0_valid = 0;
    chk("t1_we_before", rf_we, 1);
    rst_n = 0;
    #1;
    chk("t1_we_dropped", rf_we, 0);
    chk("t1_busy", busy, '0);
    bus.wb0_valid = 1;
    #1;
    chk("t1_ready_in_rst", bus.wb0_ready, 0);
    bus.wb0_valid = 0;
    model_reset();
    @(posedge clk);
    #2;
    rst_n = 1;

    // Contention: grants alternate starting with src1
    bus.wb0_valid = 1; bus.wb0_addr = 10; bus.wb0_data = 32'hA000_0000;
    bus.wb1_valid = 1; bus.wb1_addr = 11; bus.wb1_data = 32'hB000_0000;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("t3_wb1_grant", bus.wb1_ready, exp_seq[c]);
      chk("t3_wb0_grant", bus.wb0_ready, !exp_seq[c]);
      tick();
      if (lg0) bus.wb0_data = bus.wb0_data + 1;
      if (lg1) bus.wb1_data = bus.wb1_data + 1;
    end
    drive_idle();
    tick();

    // Single reservation and writeback
    bus.rsv_valid = 1; bus.rsv_addr = 5;
    tick();
    bus.rsv_valid = 0;
    chk("t2_busy5_set", busy[5], 1);
    bus.wb0_valid = 1; bus.wb0_addr = 5; bus.wb0_data = 32'h0000_DEAD;
    tick();
    bus.wb0_valid = 0;
    chk("t2_we", rf_we, 1);
    chk("t2_waddr", rf_waddr, 5);
    chk("t2_wdata", rf_wdata, 32'h0000_DEAD);
    chk("t2_busy5_held", busy[5], 1);
    tick();
    chk("t2_we_pulse", rf_we, 0);
    chk("t2_busy5_clr", busy[5], 0);

    // RAW stall and WAW reservation ordering on r7
    bus.rsv_valid = 1; bus.rsv_addr = 7;
    tick();
    rs_addr = 7;
    #1;
    chk("t4_stall_set", stall, 1);
    chk("t4_rsv_wait", bus.rsv_ready, 0);
    bus.wb1_valid = 1; bus.wb1_addr = 7; bus.wb1_data = 32'h77;
    tick();
    bus.wb1_valid = 0;
    #1;
    chk("t4_stall_we", stall, 1);
    chk("t4_rsv_wait_we", bus.rsv_ready, 0);
    tick();
    chk("t4_stall_clr", stall, 0);
    chk("t4_rsv_ok", bus.rsv_ready, 1);
    tick();
    bus.rsv_valid = 0;
    chk("t4_rsv2_busy", busy[7], 1);
    bus.wb0_valid = 1; bus.wb0_addr = 7; bus.wb0_data = 32'h7777;
    tick();
    bus.wb0_valid = 0;
    tick();
    rs_addr = 0;
    chk("t4_busy7_done", busy[7], 0);

    // Register zero
    bus.wb1_valid = 1; bus.wb1_addr = 0; bus.wb1_data = 32'hFFFF_FFFF;
    #1;
    chk("t5_wb1_ready", bus.wb1_ready, 1);
    tick();
    bus.wb1_valid = 0;
    chk("t5_no_we", rf_we, 0);
    bus.rsv_valid = 1; bus.rsv_addr = 0;
    #1;
    chk("t5_rsv0_ready", bus.rsv_ready, 1);
    tick();
    bus.rsv_valid = 0;
    chk("t5_busy_zero", busy, '0);

    // Flush with a pending writeback
    bus.rsv_valid = 1; bus.rsv_addr = 3;
    tick();
    bus.rsv_addr = 9;
    tick();
    bus.rsv_valid = 0;
    chk("t6_busy_pre", busy, 32'h0000_0208);
    flush = 1;
    tick();
    flush = 0;
    bus.rsv_valid = 1; bus.rsv_addr = 12;
    #1;
    chk("t6_rsv_blocked", bus.rsv_ready, 0);
    bus.wb1_valid = 1; bus.wb1_addr = 3; bus.wb1_data = 32'h3333;
    tick();
    bus.wb1_valid = 0;
    tick();
    chk("t6_fd_early", flush_done, 0);
    chk("t6_rsv_still_blocked", bus.rsv_ready, 0);
    tick();
    bus.rsv_valid = 0;
    chk("t6_busy_clr", busy, '0);
    chk("t6_fd_pulse", flush_done, 1);
    tick();
    chk("t6_fd_single", flush_done, 0);

    // Combinational vector table over a scoreboard holding r4 and r6
    bus.rsv_valid = 1; bus.rsv_addr = 4;
    tick();
    bus.rsv_addr = 6;
    tick();
    bus.rsv_valid = 0;
    for (int v = 0; v < 8; v++) begin
      rs_addr = tbl[v].rs; rt_addr = tbl[v].rt; bus.rsv_addr = tbl[v].ra;
      #1;
      chk("tbl_stall", stall, tbl[v].st);
      chk("tbl_rsv_ready", bus.rsv_ready, tbl[v].rr);
    end
    drive_idle();

    // Randomized traffic against the reference model
    for (int c = 0; c < 600; c++) begin
      if (bus.wb0_valid && lg0) bus.wb0_valid = 0;
      if (!bus.wb0_valid && !m_drain && $urandom_range(0, 2) == 0) begin
        bus.wb0_valid = 1; bus.wb0_addr = AW'($urandom_range(0, 15)); bus.wb0_data = $urandom;
      end
      if (bus.wb1_valid && lg1) bus.wb1_valid = 0;
      if (!bus.wb1_valid && !m_drain && $urandom_range(0, 2) == 0) begin
        bus.wb1_valid = 1; bus.wb1_addr = AW'($urandom_range(0, 15)); bus.wb1_data = $urandom;
      end
      bus.rsv_valid = 1'($urandom_range(0, 1));
      bus.rsv_addr  = AW'($urandom_range(0, 15));
      rs_addr       = AW'($urandom_range(0, 15));
      rt_addr       = AW'($urandom_range(0, 15));
      flush         = ($urandom_range(0, 49) == 0);
      tick();
    end
    drive_idle();
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
